// File: rtl/mux_tree_pkg.sv
// Shared definitions for the mux-tree generator and its deserialiser.
package mux_tree_pkg;

    // Deserialiser run states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_SHIFT  = 2'd2
    } deser_state_t;

    // Default configuration shared with the generator side
    localparam int unsigned MT_WORD_W   = 8;
    localparam int unsigned MT_WARMUP   = 4;
    localparam logic [15:0] MT_SIG_POLY = 16'h1021;
    localparam logic [15:0] MT_SIG_SEED = 16'hFFFF;

endpackage

// File: rtl/sig_misr.sv
// 16-bit serial MISR: shifts left, folds the incoming bit into the feedback tap.
module sig_misr #(
    parameter logic [15:0] SIG_POLY = 16'h1021,
    parameter logic [15:0] SIG_SEED = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        bit_in,
    output logic [15:0] sig
);

    logic [15:0] r_sig;

    // Seed on reset or run start, otherwise advance once per captured bit
    always_ff @(posedge clk) begin
        if (rst || load) begin
            r_sig <= SIG_SEED;
        end else if (step) begin
            r_sig <= {r_sig[14:0], 1'b0} ^ ((r_sig[15] ^ bit_in) ? SIG_POLY : '0);
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/mux_tree_deser.sv
// Serial-to-parallel receiver for the mux-tree output: drops warm-up bits,
// packs LSB-first words onto a valid/ready port and signs every captured bit.
module mux_tree_deser
    import mux_tree_pkg::*;
#(
    parameter int unsigned WORD_W   = MT_WORD_W,
    parameter int unsigned WARMUP   = MT_WARMUP,
    parameter logic [15:0] SIG_POLY = MT_SIG_POLY,
    parameter logic [15:0] SIG_SEED = MT_SIG_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              v_in,
    input  logic              v_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [15:0]       sig,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned BC_W = $clog2(WORD_W + 1);
    // Guard keeps the counter at least one bit wide when WARMUP is 0
    localparam int unsigned WC_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    deser_state_t      r_state;
    logic [BC_W-1:0]   r_bitcnt;
    logic [WC_W-1:0]   r_wcnt;
    logic [WORD_W-1:0] r_shift;
    logic [WORD_W-1:0] r_word_data;
    logic              r_word_valid;
    logic              r_overflow;

    logic [WC_W-1:0]   w_wcnt_next;
    logic              w_last_bit;
    logic [WORD_W-1:0] w_word;
    logic              w_misr_load;
    logic              w_misr_step;

    assign w_wcnt_next = r_wcnt + 1'b1;
    assign w_last_bit  = (r_bitcnt == BC_W'(WORD_W - 1));
    // Top bit comes straight from v_in; lower bits were all rewritten this word
    assign w_word      = {v_in, r_shift[WORD_W-2:0]};
    assign w_misr_load = (r_state == ST_IDLE) && en;
    assign w_misr_step = (r_state == ST_SHIFT) && en && v_valid;

    sig_misr #(
        .SIG_POLY (SIG_POLY),
        .SIG_SEED (SIG_SEED)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .load   (w_misr_load),
        .step   (w_misr_step),
        .bit_in (v_in),
        .sig    (sig)
    );

    // Run FSM, counters, shift register and output word register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bitcnt     <= '0;
            r_wcnt       <= '0;
            r_shift      <= '0;
            r_word_data  <= '0;
            r_word_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (r_word_valid && word_ready) begin
                r_word_valid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state    <= (WARMUP == 0) ? ST_SHIFT : ST_WARMUP;
                        r_overflow <= 1'b0;
                        r_wcnt     <= '0;
                        r_bitcnt   <= '0;
                        r_shift    <= '0;
                    end
                end
                ST_WARMUP: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                    end else if (v_valid) begin
                        if (w_wcnt_next == WC_W'(WARMUP)) begin
                            r_state <= ST_SHIFT;
                            r_wcnt  <= '0;
                        end else begin
                            r_wcnt <= w_wcnt_next;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!en) begin
                        r_state <= ST_IDLE;
                    end else if (v_valid) begin
                        r_shift <= (r_shift & ~(WORD_W'(1) << r_bitcnt))
                                 | (WORD_W'(v_in) << r_bitcnt);
                        if (w_last_bit) begin
                            r_bitcnt <= '0;
                            if (!r_word_valid || word_ready) begin
                                r_word_data  <= w_word;
                                r_word_valid <= 1'b1;
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign word_data  = r_word_data;
    assign word_valid = r_word_valid;
    assign overflow   = r_overflow;
    assign busy       = (r_state != ST_IDLE);

endmodule
